// File: rtl/acc_iq_avg_ctrl_if.sv
// Bundle of the control, sample-strobe and accumulator-command signals of acc_iq_avg_ctrl.
// master drives the requests and samples; slave is the controller itself.
interface acc_iq_avg_ctrl_if #(
  parameter int CHAN_BITS = 8,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     n_acc;
  logic                 in_valid;
  logic                 in_sof;
  logic                 acc_we;
  logic [CHAN_BITS-1:0] acc_addr;
  logic                 acc_first;
  logic                 busy;
  logic                 done;
  logic [31:0]          status;

  modport master (
    output start, abort, n_acc, in_valid, in_sof,
    input  acc_we, acc_addr, acc_first, busy, done, status
  );

  modport slave (
    input  start, abort, n_acc, in_valid, in_sof,
    output acc_we, acc_addr, acc_first, busy, done, status
  );
endinterface

// File: rtl/acc_iq_avg_ctrl.sv
// Frame-averaging controller: walks IQ samples through channel/frame counters and issues
// one accumulator write per accepted sample, then drains the accumulator pipeline.
module acc_iq_avg_ctrl #(
  parameter int CHAN_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic              user_clk,
  input  logic              user_rst,
  acc_iq_avg_ctrl_if.slave  bus
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]        DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [CHAN_BITS-1:0] CHAN_LAST  = '1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t               state_reg, state_next;
  logic                 start_q_reg, start_q_next;
  logic [CNT_W-1:0]     nacc_reg, nacc_next;
  logic [CHAN_BITS-1:0] chan_reg, chan_next;
  logic [CNT_W-1:0]     frame_reg, frame_next;
  logic [DW-1:0]        drain_reg, drain_next;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;
  logic                 busy_reg, busy_next;
  logic                 we_reg, we_next;
  logic [CHAN_BITS-1:0] addr_reg, addr_next;
  logic                 first_reg, first_next;
  logic [31:0]          status_reg, status_next;

  logic                 start_edge;
  logic                 take;
  logic [CHAN_BITS-1:0] ch;

  assign start_edge = bus.start & ~start_q_reg;

  always_comb begin
    state_next   = state_reg;
    start_q_next = bus.start;
    nacc_next    = nacc_reg;
    chan_next    = chan_reg;
    frame_next   = frame_reg;
    drain_next   = drain_reg;
    err_next     = err_reg;
    done_next    = done_reg;
    we_next      = 1'b0;
    addr_next    = '0;
    first_next   = 1'b0;
    take         = 1'b0;
    ch           = chan_reg;

    if (bus.abort) begin
      // Abort wins over everything; err is left as-is so software can still see it.
      state_next = IDLE;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_edge) begin
            state_next = ARM;
            nacc_next  = (bus.n_acc == '0) ? CNT_W'(1) : bus.n_acc;
            done_next  = 1'b0;
            err_next   = 1'b0;
            frame_next = '0;
            chan_next  = '0;
          end
        end
        ARM: begin
          if (bus.in_valid && bus.in_sof) begin
            take = 1'b1;
            ch   = '0;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            if (bus.in_sof && (chan_reg != '0)) begin
              err_next   = 1'b1;
              state_next = IDLE;
            end else begin
              take = 1'b1;
              ch   = chan_reg;
            end
          end
        end
        DRAIN: begin
          if (drain_reg == DRAIN_LAST) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            drain_next = drain_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      // Shared sample path for the ARM entry sample and every ACCUM sample.
      if (take) begin
        we_next    = 1'b1;
        addr_next  = ch;
        first_next = (frame_reg == '0);
        chan_next  = ch + 1'b1;
        state_next = ACCUM;
        if (ch == CHAN_LAST) begin
          frame_next = frame_reg + 1'b1;
          if ((frame_reg + 1'b1) == nacc_reg) begin
            state_next = DRAIN;
            drain_next = '0;
          end
        end
      end
    end

    busy_next = (state_next == ARM) || (state_next == ACCUM) || (state_next == DRAIN);
  end

  // Status word is built from next-state values so it lands in the same cycle as the flags.
  for (genvar gi = 0; gi < 32; gi++) begin : g_status
    if (gi == 31) begin : g_done
      assign status_next[gi] = done_next;
    end else if (gi == 30) begin : g_busy
      assign status_next[gi] = busy_next;
    end else if (gi == 29) begin : g_err
      assign status_next[gi] = err_next;
    end else if (gi < CNT_W) begin : g_frame
      assign status_next[gi] = frame_next[gi];
    end else begin : g_zero
      assign status_next[gi] = 1'b0;
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_reg   <= IDLE;
      start_q_reg <= 1'b1;
      nacc_reg    <= '0;
      chan_reg    <= '0;
      frame_reg   <= '0;
      drain_reg   <= '0;
      err_reg     <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      first_reg   <= 1'b0;
      status_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= start_q_next;
      nacc_reg    <= nacc_next;
      chan_reg    <= chan_next;
      frame_reg   <= frame_next;
      drain_reg   <= drain_next;
      err_reg     <= err_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      first_reg   <= first_next;
      status_reg  <= status_next;
    end
  end

  assign bus.acc_we    = we_reg;
  assign bus.acc_addr  = addr_reg;
  assign bus.acc_first = first_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.status    = status_reg;

endmodule

// File: tb/tb_acc_iq_avg_ctrl.sv
// Scoreboard bench for acc_iq_avg_ctrl: expected accumulator writes are queued as samples
// are driven and matched against acc_we/acc_addr/acc_first as the controller issues them.
module tb_acc_iq_avg_ctrl;
  localparam int CB = 2;
  localparam int CW = 16;
  localparam int DC = 3;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  always #5 user_clk = ~user_clk;

  acc_iq_avg_ctrl_if #(.CHAN_BITS(CB), .CNT_W(CW)) bus ();

  acc_iq_avg_ctrl #(.CHAN_BITS(CB), .CNT_W(CW), .DRAIN_CYC(DC)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  typedef struct {
    logic [CB-1:0] addr;
    logic          first;
    int            at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // Write monitor: every acc_we must match the head of the queue, on the promised cycle.
  always @(posedge user_clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (bus.acc_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", 32'(bus.acc_we), 0);
      end else begin
        e = exp_q.pop_front();
        $display("cyc=%0d acc_we addr=%0d first=%0d", cyc, bus.acc_addr, bus.acc_first);
        check_eq("acc_addr", 32'(bus.acc_addr), 32'(e.addr));
        check_eq("acc_first", 32'(bus.acc_first), 32'(e.first));
        check_eq("we_latency", 32'(cyc), 32'(e.at_cyc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
      e = exp_q.pop_front();
      check_eq("missing_we", 32'(bus.acc_we), 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge user_clk);
  endtask

  task automatic push(input logic [CB-1:0] addr, input logic first);
    exp_t e;
    e.addr   = addr;
    e.first  = first;
    e.at_cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic sof, input logic expect_it, input logic [CB-1:0] addr,
                      input logic first);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    if (expect_it) push(addr, first);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic first);
    for (int ch = 0; ch < (1 << CB); ch++) send(ch == 0, 1'b1, CB'(ch), first);
  endtask

  task automatic start_acc(input int n);
    bus.start = 1'b0;
    tick();
    bus.n_acc = CW'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] want_status, input string tag);
    for (int i = 0; i < DC; i++) begin
      check_eq({tag, "_done_early"}, 32'(bus.done), 0);
      tick();
    end
    check_eq({tag, "_done"}, 32'(bus.done), 1);
    check_eq({tag, "_status"}, bus.status, want_status);
  endtask

  initial begin
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    bus.n_acc    = '0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;

    // Reset with start held high
    repeat (3) tick();
    check_eq("rst_status", bus.status, 0);
    check_eq("rst_flags", {28'b0, bus.busy, bus.done, bus.acc_we, bus.acc_first}, 0);
    check_eq("rst_addr", 32'(bus.acc_addr), 0);
    user_rst = 1'b0;
    repeat (3) tick();
    check_eq("held_start_idle", 32'(bus.busy), 0);

    // Two frames, contiguous, plus an ignored non-sof sample in ARM
    start_acc(2);
    check_eq("t1_arm_status", bus.status, 32'h4000_0000);
    send(1'b0, 1'b0, '0, 1'b0);
    send_frame(1'b1);
    send_frame(1'b0);
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b1;
    wait_done(32'h8000_0002, "t1");
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;

    // n_acc=0 behaves as one frame, then abort clears done
    start_acc(0);
    send_frame(1'b1);
    wait_done(32'h8000_0001, "t2_nacc0");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t2_abort_done", 32'(bus.done), 0);

    // Sync error at channel 2 of frame 1
    start_acc(3);
    send_frame(1'b1);
    send(1'b1, 1'b1, 2'd0, 1'b0);
    send(1'b0, 1'b1, 2'd1, 1'b0);
    send(1'b1, 1'b0, '0, 1'b0);
    check_eq("t3_err_status", bus.status, 32'h2000_0001);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t3_err_kept", 32'(bus.status[29]), 1);
    start_acc(1);
    check_eq("t3_err_cleared", bus.status, 32'h4000_0000);
    send_frame(1'b1);
    wait_done(32'h8000_0001, "t3_restart");

    // Abort coincident with a valid sample
    start_acc(2);
    send_frame(1'b1);
    send(1'b1, 1'b1, 2'd0, 1'b0);
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    check_eq("t4_abort_busy", 32'(bus.busy), 0);
    check_eq("t4_abort_done", 32'(bus.done), 0);
    tick();

    // Abort beats a simultaneous start edge
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_eq("t5_abort_vs_start", 32'(bus.busy), 0);
    tick();
    check_eq("t5_still_idle", 32'(bus.busy), 0);

    // Second start edge inside ACCUM is ignored
    start_acc(1);
    send(1'b1, 1'b1, 2'd0, 1'b1);
    bus.start = 1'b1;
    send(1'b0, 1'b1, 2'd1, 1'b1);
    send(1'b0, 1'b1, 2'd2, 1'b1);
    send(1'b0, 1'b1, 2'd3, 1'b1);
    wait_done(32'h8000_0001, "t6_restart_ignored");

    // Random in_valid gaps
    start_acc(2);
    for (int i = 0; i < 8; i++) begin
      send((i % 4) == 0, 1'b1, CB'(i % 4), i < 4);
      if (i < 7) repeat ($urandom_range(0, 5)) tick();
    end
    wait_done(32'h8000_0002, "t7_gaps");

    // Reset while a write is on the output
    start_acc(2);
    send(1'b1, 1'b1, 2'd0, 1'b1);
    bus.in_valid = 1'b1;
    push(2'd1, 1'b1);
    @(posedge user_clk);
    #3;
    user_rst = 1'b1;
    #1;
    check_eq("t8_rst_we", 32'(bus.acc_we), 0);
    check_eq("t8_rst_status", bus.status, 0);
    bus.in_valid = 1'b0;
    tick();
    user_rst = 1'b0;
    repeat (2) tick();
    check_eq("t8_idle_after_rst", 32'(bus.busy), 0);

    check_eq("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
